// File: rtl/sysid_ext.sv
// sysid_ext: system-ID slave with version/caps words, uptime counter and scratch registers.
// Optional feature macro SYSID_EXT_UPTIME_EN builds the 64-bit uptime counter (addresses 4/5).
module sysid_ext #(
  parameter logic [31:0] SYSTEM_ID     = 32'h00000000,
  parameter logic [31:0] TIMESTAMP     = 32'd1319998626,
  parameter logic [31:0] VERSION       = 32'h00010000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned SCRATCH_COUNT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  typedef enum logic [2:0] {
    A_SYSID   = 3'd0,
    A_TSTAMP  = 3'd1,
    A_VERSION = 3'd2,
    A_CAPS    = 3'd3,
    A_UP_LO   = 3'd4,
    A_UP_HI   = 3'd5,
    A_SCR0    = 3'd6,
    A_SCR1    = 3'd7
  } addr_e;

`ifdef SYSID_EXT_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPS = {17'd0, 3'(READ_LATENCY), 3'd0, UPTIME_PRESENT,
                                  8'(SCRATCH_COUNT)};

  addr_e       addr;
  logic [31:0] rd_word;
  logic [31:0] up_lo;
  logic [31:0] up_hi;
  logic [31:0] scratch [2];
  logic [31:0] pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld;

  assign addr = addr_e'(address);

`ifdef SYSID_EXT_UPTIME_EN
  logic [63:0] uptime;
  logic [31:0] hi_snap;

  // A clear write wins over a concurrent UPTIME_LO snapshot, so hi_snap stays coherent at 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime  <= '0;
      hi_snap <= '0;
    end else if (write && addr == A_UP_LO && writedata[0]) begin
      uptime  <= '0;
      hi_snap <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values; hi_snap gets the
      // same counter value that the LO read returns this cycle.
      uptime <= uptime + 64'd1;
      if (read && addr == A_UP_LO) hi_snap <= uptime[63:32];
    end
  end

  assign up_lo = uptime[31:0];
  assign up_hi = hi_snap;
`else
  assign up_lo = '0;
  assign up_hi = '0;
`endif

  // Slots at or above SCRATCH_COUNT are never written and read back as 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the scratch array is architecturally cleared on reset, so it is built
      // from flops with reset rather than a RAM.
      for (int i = 0; i < 2; i++) scratch[i] <= '0;
    end else if (write && address[2:1] == 2'b11 && {31'd0, address[0]} < SCRATCH_COUNT) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch[address[0]][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves rd_word unassigned (no latch).
    rd_word = '0;
    case (addr)
      A_SYSID:   rd_word = SYSTEM_ID;
      A_TSTAMP:  rd_word = TIMESTAMP;
      A_VERSION: rd_word = VERSION;
      A_CAPS:    rd_word = CAPS;
      A_UP_LO:   rd_word = up_lo;
      A_UP_HI:   rd_word = up_hi;
      A_SCR0:    if (SCRATCH_COUNT > 0) rd_word = scratch[0];
      A_SCR1:    if (SCRATCH_COUNT > 1) rd_word = scratch[1];
    endcase
  end

  // Fixed-latency return pipe; idle stages carry 0 so readdata is 0 whenever not valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0]  <= read;
      pipe_data[0] <= read ? rd_word : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign readdata      = pipe_data[READ_LATENCY-1];
  assign readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule

// File: doc/sysid_ext.md
# sysid_ext

Parametrised system-identification peripheral for the Qsys/SOPC interconnect. It extends the two-word ID/timestamp slave with a build-version word, a capability word, a free-running 64-bit uptime counter with coherent snapshot reads, and writable scratch registers. Reads are pipelined with a configurable fixed latency. Software uses it at boot to confirm that the loaded image matches the expected hardware build.

## Interface
Parameters:
- SYSTEM_ID, 32'h00000000, value returned at address 0.
- TIMESTAMP, 32'd1319998626, build timestamp in Unix seconds, returned at address 1.
- VERSION, 32'h00010000, build version word, returned at address 2.
- READ_LATENCY, 1, cycles from read strobe to readdatavalid; legal range 1–4.
- SCRATCH_COUNT, 2, number of scratch registers; legal range 0–2.

Ports:
- clock  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  3  word address.
- read  input  1  read strobe, single cycle per transfer.
- write  input  1  write strobe, single cycle per transfer.
- writedata  input  32  write data.
- byteenable  input  4  byte lanes for scratch writes.
- readdata  output  32  read data; valid only while readdatavalid is high.
- readdatavalid  output  1  read-return qualifier.

## Operation
- Address map: 0 SYSTEM_ID; 1 TIMESTAMP; 2 VERSION; 3 CAPS; 4 UPTIME_LO; 5 UPTIME_HI; 6 SCRATCH0; 7 SCRATCH1.
- CAPS fields: [7:0] = SCRATCH_COUNT; [8] = 1 when the uptime counter is present; [14:12] = READ_LATENCY; all other bits 0.
- Addresses 0–3 are read-only. Writes to them are ignored.
- Uptime counter:
  - 64 bits wide; increments by 1 every cycle; wraps from all-ones to 0.
  - A read of UPTIME_LO returns the low word and, in the same cycle, latches the high word into hi_snap.
  - A read of UPTIME_HI returns hi_snap, never the live high word.
- Writing UPTIME_LO with writedata[0]=1 clears the counter and hi_snap; the counter reads 0 on the following cycle. Writes with writedata[0]=0 and writes to UPTIME_HI are ignored.
- Scratch registers are 32-bit read/write and honour byteenable per byte. Addresses for scratch registers at or above SCRATCH_COUNT read 0 and ignore writes.
- Read pipeline:
  - The source word is sampled in the cycle read is high.
  - The sample is shifted through READ_LATENCY register stages.
  - readdatavalid and readdata are driven from the last stage.
  - Back-to-back reads are accepted every cycle. There is no waitrequest.
- Simultaneous read and write in one cycle: the write takes effect, and the read returns the pre-write value.
- Reset: counter, hi_snap, scratch registers and all pipeline stages go to 0. readdatavalid=0 and readdata=0. Reads in flight are discarded and produce no readdatavalid.

## Timing
- A read issued in cycle N gives readdatavalid=1 with data in cycle N+READ_LATENCY, for exactly one cycle.
- A write in cycle N is visible to a read issued in cycle N+1.
- An UPTIME_LO sample taken in cycle N returns the counter value at cycle N; hi_snap is coherent with that value.
- Output reset values: readdata=0, readdatavalid=0.
- If reset is asserted in cycle N, no readdatavalid occurs in cycles N+1 through N+READ_LATENCY for reads issued before N.

## Configuration
- Macro: SYSID_EXT_UPTIME_EN.
- Defined: the uptime counter and hi_snap are built, and CAPS[8]=1.
- Undefined: the counter and hi_snap are not instantiated. Addresses 4 and 5 read 0 and ignore writes, and CAPS[8]=0. All other behaviour is unchanged.

## Test plan
- ID words with READ_LATENCY=2: read addresses 0, 1, 2 on consecutive cycles. Expect readdatavalid on cycles +2, +3, +4 with SYSTEM_ID, 1319998626 and 32'h00010000 in order.
- Scratch byte lanes: write 32'hDEADBEEF to SCRATCH0 with byteenable=4'b0101, then read it back. Expect 32'h00AD00EF. With SCRATCH_COUNT=1, a write to SCRATCH1 followed by a read returns 0.
- Uptime coherence: force the counter to 64'h00000000_FFFFFFFE, read UPTIME_LO, then read UPTIME_HI three cycles later. Expect LO=32'hFFFFFFFE and HI=0, not 1.
- Uptime clear: write 1 to address 4, then read UPTIME_LO on the next cycle. Expect 0. Writing 0 to address 4 leaves the counter running.
- Reset mid-read with READ_LATENCY=3: issue a read, assert reset on the following cycle. Expect no readdatavalid and readdata=0.
- CAPS with macro undefined, READ_LATENCY=4, SCRATCH_COUNT=2: read address 3. Expect 32'h00004002. Reads of addresses 4 and 5 return 0.
